// File: rtl/snake_pkg.sv
// Shared types and constants for the snake tile renderer: grid geometry,
// tile codes, colour table and the tile address helper.
package snake_pkg;

   localparam int unsigned H_ACTIVE   = 640;
   localparam int unsigned V_ACTIVE   = 480;
   localparam int unsigned TILE_SHIFT = 5;
   localparam int unsigned GRID_W     = H_ACTIVE >> TILE_SHIFT;
   localparam int unsigned GRID_H     = V_ACTIVE >> TILE_SHIFT;
   localparam int unsigned TILES      = GRID_W * GRID_H;
   localparam int unsigned ADDR_W     = 9;
   localparam int unsigned CNT_W      = 10;
   localparam int unsigned X_W        = 5;
   localparam int unsigned Y_W        = 4;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BODY  = 2'd1,
      HEAD  = 2'd2,
      FOOD  = 2'd3
   } tile_t;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb_t;

   localparam rgb_t COL_EMPTY = 12'h000;
   localparam rgb_t COL_BODY  = 12'h0F0;
   localparam rgb_t COL_HEAD  = 12'h8F8;
   localparam rgb_t COL_FOOD  = 12'hF00;

   // y*20 + x without a multiplier
   function automatic logic [ADDR_W-1:0] tile_addr(input logic [Y_W-1:0] y,
                                                   input logic [X_W-1:0] x);
      return (ADDR_W'(y) << 4) + (ADDR_W'(y) << 2) + ADDR_W'(x);
   endfunction

endpackage

// File: rtl/snake_tile_ram.sv
// 300 x 2-bit tile store: one write port, one registered read port that
// advances only on the pixel strobe. Read-during-write returns old data.
module snake_tile_ram
   import snake_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  tile_t             wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output tile_t             rdata
);

   tile_t mem [0:TILES-1];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  rdata <= EMPTY;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/snake_tile_renderer.sv
// Pixel colour stage: maps pixel coordinates onto the tile grid, looks up
// the tile code and drives R/G/B with HS/VS delayed to match (2 strobes).
module snake_tile_renderer
   import snake_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pix_en,
   input  logic [CNT_W-1:0] hcount,
   input  logic [CNT_W-1:0] vcount,
   input  logic             hs_in,
   input  logic             vs_in,
   input  logic             wr_en,
   input  logic [X_W-1:0]   wr_x,
   input  logic [Y_W-1:0]   wr_y,
   input  logic [1:0]       wr_tile,
   output logic             busy,
   output logic             HS,
   output logic             VS,
   output logic [3:0]       R,
   output logic [3:0]       G,
   output logic [3:0]       B,
   output logic             frame_tick
);

   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_RUN   = 1'b1;

   logic [0:0]        state, state_nxt;
   logic [ADDR_W-1:0] clr_addr, clr_addr_nxt;

   logic              ram_we;
   logic [ADDR_W-1:0] ram_waddr;
   tile_t             ram_wdata;
   logic [ADDR_W-1:0] ram_raddr;
   tile_t             ram_rdata;
   logic              wr_ok;
   logic              active;
   rgb_t              colour;

   logic              active_q;
   logic              hs_q;
   logic              vs_q;
   rgb_t              pix_q;

   // Clear sequencer: walk every address once after reset, then run
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_CLEAR;
         clr_addr <= '0;
      end else begin
         state    <= state_nxt;
         clr_addr <= clr_addr_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      clr_addr_nxt = clr_addr;
      if (state == ST_CLEAR) begin
         if (clr_addr == ADDR_W'(TILES - 1)) begin
            state_nxt    = ST_RUN;
            clr_addr_nxt = '0;
         end else begin
            clr_addr_nxt = clr_addr + ADDR_W'(1);
         end
      end
   end

   assign busy = (state == ST_CLEAR);

   // Write port is owned by the clearer while busy; out-of-grid writes vanish
   assign wr_ok     = wr_en && (wr_x < X_W'(GRID_W)) && (wr_y < Y_W'(GRID_H));
   assign ram_we    = busy || wr_ok;
   assign ram_waddr = busy ? clr_addr : tile_addr(wr_y, wr_x);
   assign ram_wdata = busy ? EMPTY : tile_t'(wr_tile);

   // Off-screen coordinates read address 0 so the RAM is never indexed out of range
   assign active    = (hcount < CNT_W'(H_ACTIVE)) && (vcount < CNT_W'(V_ACTIVE));
   assign ram_raddr = active ? tile_addr(Y_W'(vcount >> TILE_SHIFT), X_W'(hcount >> TILE_SHIFT))
                             : '0;

   snake_tile_ram u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .re    (pix_en),
      .raddr (ram_raddr),
      .rdata (ram_rdata)
   );

   always_comb begin
      colour = COL_EMPTY;
      case (ram_rdata)
         BODY:    colour = COL_BODY;
         HEAD:    colour = COL_HEAD;
         FOOD:    colour = COL_FOOD;
         default: colour = COL_EMPTY;
      endcase
   end

   // Stage 1 alongside the RAM read, stage 2 drives the pins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_q <= 1'b0;
         hs_q     <= 1'b1;
         vs_q     <= 1'b1;
         HS       <= 1'b1;
         VS       <= 1'b1;
         pix_q    <= COL_EMPTY;
      end else if (pix_en) begin
         active_q <= active;
         hs_q     <= hs_in;
         vs_q     <= vs_in;
         HS       <= hs_q;
         VS       <= vs_q;
         pix_q    <= (active_q && !busy) ? colour : COL_EMPTY;
      end
   end

   assign R = pix_q.r;
   assign G = pix_q.g;
   assign B = pix_q.b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) frame_tick <= 1'b0;
      else        frame_tick <= pix_en && (hcount == '0) && (vcount == CNT_W'(V_ACTIVE));
   end

endmodule

// File: tb/tb_snake_tile_renderer.sv
// Directed bench for snake_tile_renderer: clear timing, tile colours,
// write bounds, sync alignment, frame tick and mid-frame reset.
module tb_snake_tile_renderer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pix_en;
   logic [9:0] hcount;
   logic [9:0] vcount;
   logic       hs_in;
   logic       vs_in;
   logic       wr_en;
   logic [4:0] wr_x;
   logic [3:0] wr_y;
   logic [1:0] wr_tile;
   logic       busy;
   logic       HS;
   logic       VS;
   logic [3:0] R;
   logic [3:0] G;
   logic [3:0] B;
   logic       frame_tick;

   int n_vec = 0;
   int n_err = 0;

   snake_tile_renderer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pix_en     (pix_en),
      .hcount     (hcount),
      .vcount     (vcount),
      .hs_in      (hs_in),
      .vs_in      (vs_in),
      .wr_en      (wr_en),
      .wr_x       (wr_x),
      .wr_y       (wr_y),
      .wr_tile    (wr_tile),
      .busy       (busy),
      .HS         (HS),
      .VS         (VS),
      .R          (R),
      .G          (G),
      .B          (B),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic pix(input int h, input int v, input logic hs, input logic vs);
      @(negedge clk);
      hcount = 10'(h);
      vcount = 10'(v);
      hs_in  = hs;
      vs_in  = vs;
      pix_en = 1'b1;
      @(negedge clk);
      pix_en = 1'b0;
   endtask

   task automatic render(input string tag, input int h, input int v, input logic [11:0] exp);
      pix(h, v, 1'b1, 1'b1);
      pix(h, v, 1'b1, 1'b1);
      chk(tag, {R, G, B}, exp);
   endtask

   task automatic wr(input int x, input int y, input logic [1:0] t);
      @(negedge clk);
      wr_en   = 1'b1;
      wr_x    = 5'(x);
      wr_y    = 4'(y);
      wr_tile = t;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   task automatic clear_wait(input string tag);
      for (int i = 1; i <= 300; i++) begin
         @(posedge clk);
         #1;
         if (i == 50) begin
            wr_en = 1'b1; wr_x = 5'd5; wr_y = 4'd5; wr_tile = 2'd1;
         end
         if (i == 51) wr_en = 1'b0;
         if (i == 299) chk({tag, "_busy299"}, 12'(busy), 12'd1);
         if (i == 300) chk({tag, "_busy300"}, 12'(busy), 12'd0);
      end
   endtask

   logic [4:0] hs_pat = 5'b10010;
   logic [4:0] vs_pat = 5'b11001;

   initial begin
      rst_n = 1'b0; pix_en = 1'b0; hcount = '0; vcount = '0;
      hs_in = 1'b0; vs_in = 1'b0; wr_en = 1'b0; wr_x = '0; wr_y = '0; wr_tile = '0;

      repeat (3) @(negedge clk);
      chk("rst_hs",   12'(HS), 12'd1);
      chk("rst_vs",   12'(VS), 12'd1);
      chk("rst_rgb",  {R, G, B}, 12'h000);
      chk("rst_busy", 12'(busy), 12'd1);
      chk("rst_tick", 12'(frame_tick), 12'd0);

      hs_in = 1'b1; vs_in = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      clear_wait("clr");

      // every tile reads EMPTY, including (5,5) written while busy
      for (int ty = 0; ty < 15; ty++)
         for (int tx = 0; tx < 20; tx++)
            render($sformatf("empty_%0d_%0d", tx, ty), tx * 32 + 16, ty * 32 + 16, 12'h000);

      wr(3, 2, 2'd3);
      render("food_3_2", 100, 70, 12'hF00);
      render("next_4_2", 128, 70, 12'h000);

      wr(19, 14, 2'd2);
      render("head_19_14", 639, 479, 12'h8F8);
      render("hblank",     640, 479, 12'h000);
      render("vblank",     639, 480, 12'h000);

      wr(20, 0, 2'd1);
      wr(31, 0, 2'd1);
      wr(0, 15, 2'd1);
      render("oob_0_1",  16,  48, 12'h000);
      render("oob_11_1", 368, 48, 12'h000);
      render("oob_0_0",  16,  16, 12'h000);
      render("oob_0_14", 16,  464, 12'h000);

      wr(0, 0, 2'd1);
      render("body_0_0", 16, 16, 12'h0F0);

      // write and read the same tile on one clk
      @(negedge clk);
      wr_en = 1'b1; wr_x = 5'd7; wr_y = 4'd7; wr_tile = 2'd1;
      hcount = 10'd240; vcount = 10'd240; pix_en = 1'b1;
      @(negedge clk);
      wr_en = 1'b0; pix_en = 1'b0;
      pix(240, 240, 1'b1, 1'b1);
      chk("rdw_old", {R, G, B}, 12'h000);
      pix(240, 240, 1'b1, 1'b1);
      chk("rdw_new", {R, G, B}, 12'h0F0);

      // HS/VS after each strobe carry what was sampled one strobe earlier
      for (int n = 0; n < 5; n++) begin
         pix(700, 490, hs_pat[n], vs_pat[n]);
         chk($sformatf("hs_%0d", n), 12'(HS), (n == 0) ? 12'd1 : 12'(hs_pat[n-1]));
         chk($sformatf("vs_%0d", n), 12'(VS), (n == 0) ? 12'd1 : 12'(vs_pat[n-1]));
      end
      repeat (3) @(negedge clk);
      chk("hs_hold", 12'(HS), 12'(hs_pat[3]));
      pix(700, 490, 1'b1, 1'b1);
      chk("hs_last", 12'(HS), 12'(hs_pat[4]));
      chk("vs_last", 12'(VS), 12'(vs_pat[4]));

      // frame tick
      @(negedge clk);
      hcount = 10'd0; vcount = 10'd480; pix_en = 1'b0;
      @(posedge clk); #1;
      chk("tick_nostrobe", 12'(frame_tick), 12'd0);
      @(negedge clk);
      pix_en = 1'b1;
      #1 chk("tick_pre", 12'(frame_tick), 12'd0);
      @(posedge clk); #1;
      chk("tick_rise", 12'(frame_tick), 12'd1);
      @(negedge clk);
      pix_en = 1'b0;
      @(posedge clk); #1;
      chk("tick_width", 12'(frame_tick), 12'd0);
      @(negedge clk);
      vcount = 10'd481; pix_en = 1'b1;
      @(posedge clk); #1;
      chk("tick_481", 12'(frame_tick), 12'd0);
      @(negedge clk);
      hcount = 10'd1; vcount = 10'd480;
      @(posedge clk); #1;
      chk("tick_h1", 12'(frame_tick), 12'd0);
      @(negedge clk);
      pix_en = 1'b0;

      // mid-frame reset with non-reset outputs
      pix(100, 70, 1'b0, 1'b0);
      pix(100, 70, 1'b0, 1'b0);
      chk("pre_rgb", {R, G, B}, 12'hF00);
      chk("pre_hs",  12'(HS), 12'd0);
      chk("pre_vs",  12'(VS), 12'd0);
      hs_in = 1'b1; vs_in = 1'b1;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_hs",   12'(HS), 12'd1);
      chk("mid_vs",   12'(VS), 12'd1);
      chk("mid_rgb",  {R, G, B}, 12'h000);
      chk("mid_busy", 12'(busy), 12'd1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (100) @(posedge clk);
      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      clear_wait("reclr");

      render("post_3_2",   100, 70,  12'h000);
      render("post_19_14", 639, 479, 12'h000);
      render("post_0_0",   16,  16,  12'h000);
      render("post_7_7",   240, 240, 12'h000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
